wb_target_mem: RTL and testbench

//  Synthesizable Wishbone classic-cycle target (responder) backed by an internal word memory.

---
 rtl/wb_target_mem.sv | 94 +++++++++
 tb/tb_wb_target_mem.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/wb_target_mem.sv
// wb_target_mem: Wishbone classic target with internal word memory, wait states and window error
module wb_target_mem #(
    parameter int                   ADR_WIDTH   = 32,
    parameter int                   DAT_WIDTH   = 32,
    parameter int                   DEPTH_LOG2  = 8,
    parameter logic [ADR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int                   WAIT_STATES = 0
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [ADR_WIDTH-1:0]   adr,
    input  logic [DAT_WIDTH-1:0]   dat_w,
    output logic [DAT_WIDTH-1:0]   dat_r,
    input  logic                   cyc,
    input  logic                   stb,
    input  logic [DAT_WIDTH/8-1:0] sel,
    input  logic                   we,
    output logic                   ack,
    output logic                   err
);
    localparam int NB = DAT_WIDTH / 8;
    localparam int LB = $clog2(NB);
    localparam logic [ADR_WIDTH:0] LO = {1'b0, BASE_ADDR};
    localparam logic [ADR_WIDTH:0] HI = LO + ((ADR_WIDTH + 1)'(NB) << DEPTH_LOG2);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                 state;
    logic [3:0]             cnt;
    logic [ADR_WIDTH-1:0]   adr_q;
    logic [DAT_WIDTH-1:0]   dat_q;
    logic [NB-1:0]          sel_q;
    logic                   we_q;
    logic [DAT_WIDTH-1:0]   mem [2**DEPTH_LOG2];

    logic [ADR_WIDTH-1:0]   cur_adr;
    logic [DAT_WIDTH-1:0]   cur_dat;
    logic [NB-1:0]          cur_sel;
    logic                   cur_we;
    logic                   hit;
    logic [DEPTH_LOG2-1:0]  idx;
    logic                   start;
    logic                   go_resp;

    // In IDLE the request is taken straight from the bus so a zero-wait access can commit on the sampling edge
    assign cur_adr = (state == IDLE) ? adr : adr_q;
    assign cur_dat = (state == IDLE) ? dat_w : dat_q;
    assign cur_sel = (state == IDLE) ? sel : sel_q;
    assign cur_we  = (state == IDLE) ? we : we_q;
    assign hit     = ({1'b0, cur_adr} >= LO) && ({1'b0, cur_adr} < HI);
    assign idx     = cur_adr[LB+DEPTH_LOG2-1:LB];
    assign start   = (state == IDLE) && cyc && stb;
    assign go_resp = (start && WAIT_STATES == 0) || (state == WAIT && cyc && cnt == '0);

    // Control FSM with registered ack/err/dat_r, all asserted only in the RESP cycle
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            adr_q <= '0;
            dat_q <= '0;
            sel_q <= '0;
            we_q  <= 1'b0;
            ack   <= 1'b0;
            err   <= 1'b0;
            dat_r <= '0;
        end else begin
            ack   <= go_resp && hit;
            err   <= go_resp && !hit;
            dat_r <= (go_resp && hit && !cur_we) ? mem[idx] : '0;
            case (state)
                IDLE: if (start) begin
                    adr_q <= adr;
                    dat_q <= dat_w;
                    sel_q <= sel;
                    we_q  <= we;
                    cnt   <= 4'(WAIT_STATES - 1);
                    state <= (WAIT_STATES == 0) ? RESP : WAIT;
                end
                WAIT: if (!cyc) state <= IDLE;
                      else if (cnt == '0) state <= RESP;
                      else cnt <= cnt - 4'd1;
                default: state <= IDLE;
            endcase
        end
    end

    // Byte-lane memory write on the edge entering RESP; contents survive reset
    always_ff @(posedge clock) begin
        if (!reset && go_resp && hit && cur_we)
            for (int i = 0; i < NB; i++)
                if (cur_sel[i]) mem[idx][8*i +: 8] <= cur_dat[8*i +: 8];
    end
endmodule

// File: tb/tb_wb_target_mem.sv
// tb_wb_target_mem: directed checks of four wb_target_mem configurations
module tb_wb_target_mem;
    localparam int         WS[4] = '{0, 3, 0, 4};
    localparam logic [31:0] BA[4] = '{32'h0, 32'h0, 32'h1000, 32'h0};

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] adr[4], dat_w[4], dat_r[4];
    logic        cyc[4], stb[4], we[4], ack[4], err[4];
    logic [3:0]  sel[4];
    int          nvec = 0, nmis = 0;

    always #5 clock = ~clock;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        wb_target_mem #(.ADR_WIDTH(32), .DAT_WIDTH(32), .DEPTH_LOG2(8),
                        .BASE_ADDR(BA[g]), .WAIT_STATES(WS[g])) u (
            .clock(clock), .reset(reset), .adr(adr[g]), .dat_w(dat_w[g]), .dat_r(dat_r[g]),
            .cyc(cyc[g]), .stb(stb[g]), .sel(sel[g]), .we(we[g]), .ack(ack[g]), .err(err[g]));
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic xfer(input int k, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, output logic [31:0] rd, output logic a_o,
                        output logic e_o, output int lat);
        @(negedge clock);
        cyc[k] = 1'b1; stb[k] = 1'b1; we[k] = w; adr[k] = a; dat_w[k] = d; sel[k] = s;
        lat = -1; rd = '0; a_o = 1'b0; e_o = 1'b0;
        for (int n = 1; n <= 20 && lat < 0; n++) begin
            @(posedge clock); #1;
            if (ack[k] || err[k]) begin
                lat = n; rd = dat_r[k]; a_o = ack[k]; e_o = err[k];
            end
        end
        cyc[k] = 1'b0; stb[k] = 1'b0;
        @(posedge clock); #1;
        chk("pulse_end", {30'd0, ack[k], err[k]}, 32'd0);
    endtask

    logic [31:0] rd;
    logic        a_o, e_o, seen;
    int          lat, t1, t2;

    initial begin
        for (int k = 0; k < 4; k++) begin
            adr[k] = '0; dat_w[k] = '0; cyc[k] = 0; stb[k] = 0; we[k] = 0; sel[k] = '0;
        end
        #1;
        for (int k = 0; k < 4; k++)
            chk("reset_out", {ack[k], err[k], 30'd0} | dat_r[k], 32'd0);
        repeat (3) @(posedge clock);
        @(negedge clock); reset = 1'b0;

        xfer(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, rd, a_o, e_o, lat);
        chk("t1_wr_lat", lat, 1); chk("t1_wr_ack", a_o, 1); chk("t1_wr_err", e_o, 0);
        xfer(0, 0, 32'h10, 32'h0, 4'h0, rd, a_o, e_o, lat);
        chk("t1_rd_lat", lat, 1); chk("t1_rd_dat", rd, 32'hDEADBEEF); chk("t1_rd_err", e_o, 0);

        xfer(0, 1, 32'h20, 32'h11223344, 4'hF, rd, a_o, e_o, lat);
        xfer(0, 1, 32'h20, 32'hAABBCCDD, 4'h5, rd, a_o, e_o, lat);
        xfer(0, 0, 32'h20, 32'h0, 4'hF, rd, a_o, e_o, lat);
        chk("t2_lanes", rd, 32'h11BB33DD);
        xfer(0, 1, 32'h20, 32'h0, 4'h0, rd, a_o, e_o, lat);
        chk("t2_sel0_ack", a_o, 1);
        xfer(0, 0, 32'h20, 32'h0, 4'h0, rd, a_o, e_o, lat);
        chk("t2_sel0_keep", rd, 32'h11BB33DD);

        xfer(1, 1, 32'h10, 32'hCAFE0001, 4'hF, rd, a_o, e_o, lat);
        chk("t3_wr_lat", lat, 4);
        xfer(1, 0, 32'h10, 32'h0, 4'h0, rd, a_o, e_o, lat);
        chk("t3_rd_lat", lat, 4); chk("t3_rd_dat", rd, 32'hCAFE0001);
        @(negedge clock);
        cyc[1] = 1; stb[1] = 1; we[1] = 0; adr[1] = 32'h10;
        t1 = -1; t2 = -1;
        for (int n = 1; n <= 30 && t2 < 0; n++) begin
            @(posedge clock); #1;
            if (ack[1]) begin
                if (t1 < 0) t1 = n; else t2 = n;
            end
        end
        cyc[1] = 0; stb[1] = 0;
        chk("t3_b2b_first", t1, 4); chk("t3_b2b_gap", t2 - t1, 5);

        xfer(2, 1, 32'h13FC, 32'h0BADF00D, 4'hF, rd, a_o, e_o, lat);
        xfer(2, 1, 32'h1000, 32'h00C0FFEE, 4'hF, rd, a_o, e_o, lat);
        xfer(2, 1, 32'h0FFC, 32'hFFFFFFFF, 4'hF, rd, a_o, e_o, lat);
        chk("t4_lo_err", e_o, 1); chk("t4_lo_ack", a_o, 0); chk("t4_lo_lat", lat, 1);
        xfer(2, 0, 32'h1400, 32'h0, 4'h0, rd, a_o, e_o, lat);
        chk("t4_hi_err", e_o, 1); chk("t4_hi_ack", a_o, 0); chk("t4_hi_dat", rd, 32'h0);
        xfer(2, 0, 32'h1000, 32'h0, 4'h0, rd, a_o, e_o, lat);
        chk("t4_base_ack", a_o, 1); chk("t4_base_dat", rd, 32'h00C0FFEE);
        xfer(2, 0, 32'h13FC, 32'h0, 4'h0, rd, a_o, e_o, lat);
        chk("t4_top_ack", a_o, 1); chk("t4_top_dat", rd, 32'h0BADF00D);

        xfer(3, 1, 32'h30, 32'h12345678, 4'hF, rd, a_o, e_o, lat);
        chk("t5_wr_lat", lat, 5);
        @(negedge clock);
        cyc[3] = 1; stb[3] = 1; we[3] = 1; adr[3] = 32'h30; dat_w[3] = 32'h5555AAAA; sel[3] = 4'hF;
        repeat (2) @(posedge clock);
        @(negedge clock); cyc[3] = 0; stb[3] = 0;
        seen = 0;
        repeat (8) begin
            @(posedge clock); #1;
            seen = seen | ack[3] | err[3];
        end
        chk("t5_abort_quiet", seen, 0);
        xfer(3, 0, 32'h30, 32'h0, 4'h0, rd, a_o, e_o, lat);
        chk("t5_rd_lat", lat, 5); chk("t5_rd_dat", rd, 32'h12345678);

        @(negedge clock);
        cyc[3] = 1; stb[3] = 1; we[3] = 1; adr[3] = 32'h30; dat_w[3] = 32'h0F0F0F0F; sel[3] = 4'hF;
        repeat (2) @(posedge clock);
        #2 reset = 1'b1;
        #1 chk("t6_wait_rst", {ack[3], err[3], 30'd0} | dat_r[3], 32'd0);
        @(negedge clock); cyc[3] = 0; stb[3] = 0;
        repeat (6) @(posedge clock);
        @(negedge clock); reset = 1'b0;
        xfer(3, 0, 32'h30, 32'h0, 4'h0, rd, a_o, e_o, lat);
        chk("t6_rd_lat", lat, 5); chk("t6_rd_dat", rd, 32'h12345678);

        @(negedge clock);
        cyc[3] = 1; stb[3] = 1; we[3] = 0; adr[3] = 32'h30;
        seen = 0;
        for (int n = 1; n <= 20 && !seen; n++) begin
            @(posedge clock); #1;
            seen = ack[3];
        end
        chk("t6_resp_seen", seen, 1);
        #1 reset = 1'b1;
        #1 chk("t6_resp_rst", {ack[3], err[3], 30'd0} | dat_r[3], 32'd0);
        @(negedge clock); cyc[3] = 0; stb[3] = 0; reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
